ram_ctrl: RTL and testbench

Parametrised successor to the 256x16 single-port data RAM used by the processor top level. It adds generic width and depth, per-byte write enables, and a valid/ready request port. Reads return through a pipelined response with configurable latency. A hardware clear sequencer zero-fills the array after reset or on request. It sits between the processor load/store path and storage, replacing the combinational-read RAM.

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_bank.sv | 42 ++++
 rtl/ram_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ram_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and limits for the parametrised data RAM controller.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_bank.sv
// Storage array: byte-enabled synchronous write, registered read.
module ram_bank
  import ram_pkg::*;
#(
  parameter int    DATA_W    = 16,
  parameter int    ADDR_W    = 8,
  parameter int    DEPTH     = 256,
  parameter string INIT_FILE = ""
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [be_w(DATA_W)-1:0]   wbe,
  input  logic                      re,
  input  logic [ADDR_W-1:0]         raddr,
  output logic [DATA_W-1:0]         rdata
);

  localparam int BE_W = be_w(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read samples before the same-edge write lands, so it sees all earlier writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ram_ctrl.sv
// Data RAM controller: valid/ready request port, pipelined read response, clear sequencer.
// state | meaning
// CLEAR | sweeping CLR_VALUE into every word, requests blocked
// READY | array usable, one request accepted per cycle
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int               DATA_W     = 16,
  parameter int               ADDR_W     = 8,
  parameter int               DEPTH      = 256,
  parameter int               RD_LAT     = 1,
  parameter bit               CLR_ON_RST = 1'b1,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0,
  parameter string            INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  input  logic [be_w(DATA_W)-1:0] req_be,
  input  logic                    clr_req,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    init_done
);

  localparam int BE_W = be_w(DATA_W);

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("ram_ctrl: DATA_W must be a multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > 2**ADDR_W) begin : g_bad_depth
    $error("ram_ctrl: DEPTH must be in 1..2**ADDR_W");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("ram_ctrl: RD_LAT must be 1 or 2");
  end

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              hs;
  logic              rd_hs;
  logic              in_range;
  logic              last_ptr;

  assign req_ready = (state == READY);
  assign hs        = req_valid & req_ready;
  assign rd_hs     = hs & ~req_we;
  assign in_range  = 32'(req_addr) < DEPTH;
  assign last_ptr  = (clr_ptr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLR_ON_RST ? CLEAR : READY;
      clr_ptr   <= '0;
      init_done <= !CLR_ON_RST;
    end else begin
      case (state)
        CLEAR: begin
          if (last_ptr) begin
            state     <= READY;
            clr_ptr   <= '0;
            init_done <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
          end
        end
        READY: begin
          if (clr_req) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            init_done <= 1'b0;
          end
        end
      endcase
    end
  end

  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [DATA_W-1:0] bank_wdata;
  logic [BE_W-1:0]   bank_wbe;
  logic              bank_re;
  logic [DATA_W-1:0] bank_rdata;

  // The sweep owns the write port for the whole of CLEAR.
  always_comb begin
    bank_we    = 1'b0;
    bank_waddr = req_addr;
    bank_wdata = req_wdata;
    bank_wbe   = req_be;
    if (state == CLEAR) begin
      bank_we    = 1'b1;
      bank_waddr = clr_ptr;
      bank_wdata = CLR_VALUE;
      bank_wbe   = '1;
    end else begin
      bank_we = hs & req_we & in_range;
    end
  end

  assign bank_re = rd_hs & in_range;

  ram_bank #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bank_we),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .wbe   (bank_wbe),
    .re    (bank_re),
    .raddr (req_addr),
    .rdata (bank_rdata)
  );

  logic              rd_v0;
  logic              rd_e0;
  logic [DATA_W-1:0] rd_d0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v0 <= 1'b0;
      rd_e0 <= 1'b0;
    end else begin
      rd_v0 <= rd_hs;
      if (rd_hs) rd_e0 <= ~in_range;
    end
  end

  // Out-of-range reads leave the bank register untouched and are masked to zero here.
  assign rd_d0 = rd_e0 ? '0 : bank_rdata;

  if (RD_LAT == 2) begin : g_lat2
    logic              rd_v1;
    logic              rd_e1;
    logic [DATA_W-1:0] rd_d1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_v1 <= 1'b0;
        rd_e1 <= 1'b0;
        rd_d1 <= '0;
      end else begin
        rd_v1 <= rd_v0;
        if (rd_v0) begin
          rd_d1 <= rd_d0;
          rd_e1 <= rd_e0;
        end
      end
    end

    assign rsp_valid = rd_v1;
    assign rsp_rdata = rd_d1;
    assign rsp_err   = rd_e1;
  end else begin : g_lat1
    assign rsp_valid = rd_v0;
    assign rsp_rdata = rd_d0;
    assign rsp_err   = rd_e0;
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: two instances (256 deep / latency 1, 200 deep / latency 2) against a word-level model.
module tb_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [15:0] req_wdata = 16'h0000;
  logic [1:0]  req_be = 2'b00;
  logic        clr_req = 1'b0;

  logic        rdy [2];
  logic        vld [2];
  logic        err [2];
  logic        idn [2];
  logic [15:0] dat [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .clr_req(clr_req), .rsp_valid(vld[0]), .rsp_rdata(dat[0]), .rsp_err(err[0]),
    .init_done(idn[0])
  );

  ram_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .RD_LAT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .clr_req(clr_req), .rsp_valid(vld[1]), .rsp_rdata(dat[1]), .rsp_err(err[1]),
    .init_done(idn[1])
  );

  function automatic int dep(input int k);
    return (k == 0) ? 256 : 200;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: words per instance, sweep cycles remaining, and a two-deep response delay line.
  logic [15:0] mm [2][256];
  int          left [2];
  logic        s1v [2], s2v [2], s1e [2], s2e [2];
  logic [15:0] s1d [2], s2d [2];
  logic        ev [2], ee [2];
  logic [15:0] ed [2];
  logic        hs_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        left[k] = dep(k);
        s1v[k] = 1'b0; s2v[k] = 1'b0;
        ev[k] = 1'b0; ee[k] = 1'b0; ed[k] = 16'h0000;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        hs_m = req_valid && (left[k] == 0);
        s2v[k] = s1v[k]; s2d[k] = s1d[k]; s2e[k] = s1e[k];
        s1v[k] = 1'b0;
        if (hs_m && !req_we) begin
          s1v[k] = 1'b1;
          s1e[k] = int'(req_addr) >= dep(k);
          s1d[k] = s1e[k] ? 16'h0000 : mm[k][req_addr];
        end
        if (hs_m && req_we && int'(req_addr) < dep(k)) begin
          for (int b = 0; b < 2; b++)
            if (req_be[b]) mm[k][req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
        end
        if (left[k] > 0) begin
          mm[k][dep(k) - left[k]] = 16'h0000;
          left[k]--;
        end else if (clr_req) begin
          left[k] = dep(k);
        end
        ev[k] = (lat(k) == 1) ? s1v[k] : s2v[k];
        if (ev[k]) begin
          ed[k] = (lat(k) == 1) ? s1d[k] : s2d[k];
          ee[k] = (lat(k) == 1) ? s1e[k] : s2e[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model_ready%0d", k), rdy[k], left[k] == 0);
      chk($sformatf("model_init_done%0d", k), idn[k], left[k] == 0);
      chk($sformatf("model_rsp_valid%0d", k), vld[k], ev[k]);
      chk($sformatf("model_rsp_rdata%0d", k), dat[k], ed[k]);
      chk($sformatf("model_rsp_err%0d", k), err[k], ee[k]);
    end
  end

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  // Read on both instances; checks each response exactly at its own latency.
  task automatic rd2(input logic [7:0] a, input logic [15:0] d0, input logic e0,
                     input logic [15:0] d1, input logic e1, input logic clr);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; clr_req = clr;
    @(posedge clk); #1;
    req_valid = 1'b0; clr_req = 1'b0;
    chk($sformatf("rd%0d_valid0", a), vld[0], 1'b1);
    chk($sformatf("rd%0d_data0", a), dat[0], d0);
    chk($sformatf("rd%0d_err0", a), err[0], e0);
    @(posedge clk); #1;
    chk($sformatf("rd%0d_pulse0", a), vld[0], 1'b0);
    chk($sformatf("rd%0d_valid1", a), vld[1], 1'b1);
    chk($sformatf("rd%0d_data1", a), dat[1], d1);
    chk($sformatf("rd%0d_err1", a), err[1], e1);
  endtask

  // Counts cycles until instance 0 is ready; optionally pulses clr_req mid-sweep.
  task automatic wait_ready(input string nm, input int exp_cnt, input int pulse_at);
    int cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
      clr_req = (cnt == pulse_at);
    end while (!rdy[0] && cnt < 400);
    clr_req = 1'b0;
    chk(nm, cnt, exp_cnt);
    chk({nm, "_ready1"}, rdy[1], 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready0", rdy[0], 1'b0);
    chk("reset_init_done0", idn[0], 1'b0);
    chk("reset_rdata0", dat[0], 16'h0000);
    rst_n = 1'b1;
    wait_ready("sweep_after_reset", 256, -1);

    rd2(8'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    rd2(8'd128, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    rd2(8'd255, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);

    wr(8'd5, 16'hABCD, 2'b11);
    wr(8'd5, 16'h1234, 2'b01);
    rd2(8'd5, 16'hAB34, 1'b0, 16'hAB34, 1'b0, 1'b0);

    for (int i = 1; i <= 3; i++) wr(8'(i), 16'(i * 17), 2'b11);
    for (int i = 1; i <= 5; i++) begin
      req_we = 1'b0;
      req_valid = (i <= 3);
      req_addr = 8'(i);
      @(posedge clk); #1;
      if (i <= 3) chk($sformatf("b2b_data0_%0d", i), dat[0], 16'(i * 17));
      if (i >= 2 && i <= 4) begin
        chk($sformatf("b2b_valid1_%0d", i), vld[1], 1'b1);
        chk($sformatf("b2b_data1_%0d", i), dat[1], 16'((i - 1) * 17));
      end
      if (i == 5) chk("b2b_tail1", vld[1], 1'b0);
    end
    req_valid = 1'b0;

    wr(8'd210, 16'hFFFF, 2'b11);
    rd2(8'd210, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0);
    rd2(8'd10, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

    wr(8'd7, 16'h0077, 2'b11);
    rd2(8'd7, 16'h0077, 1'b0, 16'h0077, 1'b0, 1'b1);
    wait_ready("sweep_after_clr", 255, 50);
    rd2(8'd7, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

    wr(8'd3, 16'h5A5A, 2'b11);
    rd2(8'd3, 16'h5A5A, 1'b0, 16'h5A5A, 1'b0, 1'b0);
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    chk("hold_rdata0", dat[0], 16'h5A5A);
    rst_n = 1'b0;
    #1;
    chk("async_ready0", rdy[0], 1'b0);
    chk("async_init_done0", idn[0], 1'b0);
    chk("async_rdata0", dat[0], 16'h0000);
    chk("async_rdata1", dat[1], 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready("sweep_after_midreset", 256, -1);

    wr(8'd9, 16'hBEEF, 2'b10);
    rd2(8'd9, 16'hBE00, 1'b0, 16'hBE00, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
